// File: rtl/video_pkg.sv
// Shared raster types, default timing/levels and counter-width helper for the composite video generator.
// Combinational definitions only; no latency or backpressure of its own.
package video_pkg;

  typedef enum logic [1:0] {PH_SYNC, PH_BACK, PH_ACTIVE, PH_FRONT} phase_e;

  localparam int DEF_DAC_W    = 8;
  localparam int DEF_H_TOTAL  = 400;
  localparam int DEF_H_SYNC   = 30;
  localparam int DEF_H_BACK   = 40;
  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_V_TOTAL  = 262;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BLANK  = 20;
  localparam int DEF_SYNC_LVL = 0;
  localparam int DEF_BLACK_LVL = 77;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic phase_e phase_of(input int h, input int h_sync, input int h_back,
                                      input int h_active);
    if (h < h_sync) return PH_SYNC;
    if (h < h_sync + h_back) return PH_BACK;
    if (h < h_sync + h_back + h_active) return PH_ACTIVE;
    return PH_FRONT;
  endfunction

endpackage

// File: rtl/line_buffer_pp.sv
// Two-bank line store: writes land in the back bank, reads come from the front bank one clock later.
// No backpressure here; the caller gates writes and pulses swap at the line boundary.
module line_buffer_pp
  import video_pkg::*;
#(
  parameter int DAC_W = DEF_DAC_W,
  parameter int DEPTH = DEF_H_ACTIVE,
  parameter int AW    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             swap,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DAC_W-1:0] wr_dat,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [DAC_W-1:0] rd_dat
);

  logic [DAC_W-1:0] bank0 [DEPTH];
  logic [DAC_W-1:0] bank1 [DEPTH];
  logic             bank_sel;  // index of the front (displayed) bank

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bank_sel <= 1'b0;
    else if (swap) bank_sel <= ~bank_sel;
  end

  always_ff @(posedge clk) begin
    if (wr_en && !bank_sel) bank1[wr_addr] <= wr_dat;
    if (wr_en && bank_sel) bank0[wr_addr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_dat <= '0;
    else if (rd_en) rd_dat <= bank_sel ? bank1[rd_addr] : bank0[rd_addr];
  end

endmodule

// File: rtl/video_gen_pp.sv
// Composite video generator: raster timer, ping-pong line buffer, level mux; dac lags hcount by 1 clk.
// wr_ready drops while the back bank is full and on the swap clock; unaccepted samples are simply held upstream.
module video_gen_pp
  import video_pkg::*;
#(
  parameter int DAC_W     = DEF_DAC_W,
  parameter int H_TOTAL   = DEF_H_TOTAL,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int V_TOTAL   = DEF_V_TOTAL,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BLANK   = DEF_V_BLANK,
  parameter int SYNC_LVL  = DEF_SYNC_LVL,
  parameter int BLACK_LVL = DEF_BLACK_LVL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             wr_valid,
  input  logic [DAC_W-1:0] wr_data,
  output logic             wr_ready,
  output logic [7:0]       req_line,
  output logic [7:0]       line,
  output logic             underrun,
  output logic [DAC_W-1:0] dac
);

  localparam int HW        = cnt_w(H_TOTAL);
  localparam int VW        = cnt_w(V_TOTAL);
  localparam int AW        = cnt_w(H_ACTIVE);
  localparam int PW        = cnt_w(H_ACTIVE + 1);
  localparam int N_ACT     = V_TOTAL - V_BLANK;
  localparam int ACT_START = H_SYNC + H_BACK;

  logic [HW-1:0]    hcount;
  logic [VW-1:0]    vcount, vcount_nxt;
  logic [PW-1:0]    wptr;
  logic             front_valid;
  logic             swap_cycle, next_active, back_full, wr_acc, do_swap;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [DAC_W-1:0] rd_dat, luma_raw, luma, level;
  phase_e           phase;

  assign swap_cycle  = (hcount == HW'(H_TOTAL - 1));
  assign vcount_nxt  = (vcount == VW'(V_TOTAL - 1)) ? '0 : vcount + 1'b1;
  assign next_active = (vcount_nxt >= VW'(V_BLANK));
  assign back_full   = (wptr == PW'(H_ACTIVE));
  assign wr_ready    = !back_full && !swap_cycle;
  assign wr_acc      = wr_valid && wr_ready;
  assign do_swap     = swap_cycle && next_active && back_full;

  // Read one pixel ahead so the registered RAM output lines up with hcount.
  assign rd_en   = (hcount >= HW'(ACT_START - 1)) && (hcount < HW'(ACT_START + H_ACTIVE - 1));
  assign rd_addr = AW'(hcount - HW'(ACT_START - 1));

  line_buffer_pp #(.DAC_W(DAC_W), .DEPTH(H_ACTIVE), .AW(AW)) u_buf (
    .clk    (clk),
    .reset  (reset),
    .swap   (do_swap),
    .wr_en  (wr_acc),
    .wr_addr(AW'(wptr)),
    .wr_dat (wr_data),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_dat (rd_dat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcount      <= '0;
      vcount      <= '0;
      wptr        <= '0;
      front_valid <= 1'b0;
      req_line    <= 8'd0;
      line        <= 8'd0;
      underrun    <= 1'b0;
    end else if (swap_cycle) begin
      hcount <= '0;
      vcount <= vcount_nxt;
      if (next_active) begin
        // A partial fill is dropped; numbering still advances with the raster.
        wptr        <= '0;
        front_valid <= back_full;
        line        <= req_line;
        req_line    <= (req_line == 8'(N_ACT - 1)) ? 8'd0 : req_line + 8'd1;
        if (!back_full) underrun <= 1'b1;
      end else begin
        front_valid <= 1'b0;
      end
    end else begin
      hcount <= hcount + 1'b1;
      if (wr_acc) wptr <= wptr + 1'b1;
    end
  end

  always_comb begin
    phase    = phase_of(int'(hcount), H_SYNC, H_BACK, H_ACTIVE);
    luma_raw = DAC_W'(BLACK_LVL);
    if (mode) luma_raw = DAC_W'(hcount - HW'(ACT_START));
    else if (front_valid) luma_raw = rd_dat;
    luma  = (luma_raw < DAC_W'(BLACK_LVL)) ? DAC_W'(BLACK_LVL) : luma_raw;
    level = DAC_W'(BLACK_LVL);
    if (vcount < VW'(V_SYNC)) begin
      if (hcount < HW'(H_TOTAL - H_SYNC)) level = DAC_W'(SYNC_LVL);
    end else if (phase == PH_SYNC) begin
      level = DAC_W'(SYNC_LVL);
    end else if (vcount >= VW'(V_BLANK) && phase == PH_ACTIVE) begin
      level = luma;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dac <= DAC_W'(SYNC_LVL);
    else dac <= level;
  end

endmodule
